sm_key_ctrl: RTL and testbench
==============================

SM_KEY_CTRL -- requirements
Module: sm_key_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000; consecutive stable cycles required to accept a key level change.
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000; debounced-pressed cycles on step key required to enter RUN.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_step_n  input  1  raw step/run button, active-low, asynchronous to clk.
REQ-006 SHALL have port key_sel_n  input  1  raw register-select button, active-low, asynchronous to clk.
REQ-007 SHALL have port clkEnable  output  1  core clock enable, intended for the core's clkEnable input.
REQ-008 SHALL have port regAddr  output  5  register index for the core's debug read port.
REQ-009 SHALL have port run  output  1  mode indicator; 1 = RUN, 0 = STEP.

Function
REQ-010 SHALL pass each raw key through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized key: counter clears on mismatch with the debounced level; debounced level flips when DB_CYCLES consecutive mismatching cycles are counted.
REQ-012 SHALL generate a one-cycle press event per key on debounced released->pressed transition; release generates no event.
REQ-013 SHALL implement a two-state mode FSM: STEP (reset state) and RUN.
REQ-014 In STEP, a step-key press event SHALL drive clkEnable=1 for exactly one cycle, on the cycle after the event.
REQ-015 In STEP, a hold counter SHALL count cycles while the debounced step key is pressed, clearing on release; on reaching HOLD_CYCLES the FSM SHALL move to RUN.
REQ-016 In RUN, clkEnable SHALL be 1 every cycle and run SHALL be 1.
REQ-017 In RUN, a step-key press event SHALL return the FSM to STEP with clkEnable=0 from the next cycle and no step pulse.
REQ-018 The press that caused STEP->RUN SHALL NOT cause a RUN->STEP transition; holding the key in RUN has no effect.
REQ-019 A sel-key press event SHALL increment regAddr by 1 modulo 32 (31 -> 0) on the next cycle, in either mode.
REQ-020 Simultaneous step and sel press events SHALL each take full effect independently in the same cycle.
REQ-021 Hold counter SHALL saturate; width ceil(log2(HOLD_CYCLES+1)); debounce counter width ceil(log2(DB_CYCLES+1)).
REQ-022 Outputs SHALL be registered; no combinational path from key inputs to outputs.

Reset
REQ-023 While rst=1: FSM=STEP, clkEnable=0, run=0, regAddr=0, counters=0, debounced levels=released, synchronizers=released.
REQ-024 Reset asserted mid-press or mid-hold SHALL abort; after release of rst a key still held low SHALL be debounced afresh and produce one new press event.

Structure
REQ-025 FSM state encodings and default DB_CYCLES/HOLD_CYCLES SHALL live in the shared settings header.
REQ-026 Synchronizer+debouncer+edge detect SHALL be one sub-module, sm_debouncer, instantiated once per key.

Verification (DB_CYCLES=4, HOLD_CYCLES=16)
REQ-027 rst=1 for 3 cycles -> clkEnable=0, run=0, regAddr=0.
REQ-028 key_step_n low 10 cycles then high -> exactly one clkEnable=1 cycle, run stays 0.
REQ-029 key_step_n toggling every 2 cycles for 40 cycles (bounce) -> zero clkEnable pulses.
REQ-030 key_step_n held low 30 cycles -> one pulse, then run=1 and clkEnable=1 continuously; release, press again -> run=0, clkEnable=0, no extra pulse.
REQ-031 33 clean key_sel_n presses from reset -> regAddr 1,2,...,31,0,1.
REQ-032 Both keys pressed in the same cycle -> one clkEnable pulse and regAddr+1 on the same cycle; rst asserted mid-hold -> run stays 0.

Source files
------------

// File: rtl/sm_key_ctrl_pkg.sv
// sm_key_ctrl_pkg: shared mode encodings and default timing for the key controller.
package sm_key_ctrl_pkg;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    localparam int DEF_DB_CYCLES   = 50_000;
    localparam int DEF_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/sm_debouncer.sv
// sm_debouncer: 2-flop synchronizer, counter debouncer and press-edge detector for one active-low key.
module sm_debouncer
    import sm_key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          flip;

    // level is active-high (1 = pressed); sync holds the raw active-low samples
    assign mismatch = ~sync[1] != level;
    assign flip     = mismatch && cnt == CNT_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            cnt   <= (mismatch && !flip) ? cnt + 1'b1 : '0;
            level <= level ^ flip;
            press <= flip & ~level;
        end
    end

endmodule

// File: rtl/sm_key_ctrl.sv
// sm_key_ctrl: step/run mode controller with single-step clock enable and register-select counter.
module sm_key_ctrl
    import sm_key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_step_n,
    input  logic       key_sel_n,
    output logic       clkEnable,
    output logic [4:0] regAddr,
    output logic       run
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    mode_t         state;
    mode_t         state_nxt;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          step_lvl;
    logic          step_press;
    logic          sel_press;
    logic          sel_lvl_unused;
    logic          ce_nxt;
    logic          run_nxt;

    sm_debouncer #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_step_n),
        .level (step_lvl),
        .press (step_press)
    );

    sm_debouncer #(.DB_CYCLES(DB_CYCLES)) u_sel_db (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_sel_n),
        .level (sel_lvl_unused),
        .press (sel_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MODE_STEP;
            hold      <= '0;
            clkEnable <= 1'b0;
            run       <= 1'b0;
            regAddr   <= '0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            clkEnable <= ce_nxt;
            run       <= run_nxt;
            regAddr   <= regAddr + 5'(sel_press);
        end
    end

    // Hold counts only in STEP, so the press that entered RUN is never re-counted
    always_comb begin
        hold_nxt  = (state == MODE_STEP && step_lvl) ? hold + HW'(hold != HOLD_MAX) : '0;
        state_nxt = (state == MODE_STEP) ? (hold == HOLD_MAX ? MODE_RUN : MODE_STEP)
                                         : (step_press ? MODE_STEP : MODE_RUN);
    end

    always_comb begin
        run_nxt = state_nxt == MODE_RUN;
        ce_nxt  = run_nxt || (state == MODE_STEP && step_press);
    end

endmodule

// File: tb/tb_sm_key_ctrl.sv
// tb_sm_key_ctrl: directed self-checking bench for sm_key_ctrl with DB_CYCLES=4, HOLD_CYCLES=16.
module tb_sm_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_step_n = 1'b1;
    logic       key_sel_n = 1'b1;
    logic       clkEnable;
    logic [4:0] regAddr;
    logic       run;

    int compared = 0;
    int mismatched = 0;
    int ce_cnt = 0;
    int c0;

    sm_key_ctrl #(.DB_CYCLES(4), .HOLD_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_step_n (key_step_n),
        .key_sel_n  (key_sel_n),
        .clkEnable  (clkEnable),
        .regAddr    (regAddr),
        .run        (run)
    );

    always #5 clk = ~clk;

    // counts cycles with clkEnable high, sampled mid-cycle
    always @(negedge clk) if (clkEnable) ce_cnt <= ce_cnt + 1;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        cyc(3);
        check("rst_ce", int'(clkEnable), 0);
        check("rst_run", int'(run), 0);
        check("rst_addr", int'(regAddr), 0);
        rst = 1'b0;
        cyc(2);
        // short clean press: one step pulse
        c0 = ce_cnt;
        key_step_n = 1'b0;
        cyc(10);
        key_step_n = 1'b1;
        cyc(20);
        check("short_pulses", ce_cnt - c0, 1);
        check("short_run", int'(run), 0);
        // bounce shorter than the debounce window
        c0 = ce_cnt;
        for (int i = 0; i < 20; i++) begin
            key_step_n = ~key_step_n;
            cyc(2);
        end
        cyc(10);
        check("bounce_pulses", ce_cnt - c0, 0);
        check("bounce_run", int'(run), 0);
        // long hold: pulse then RUN (1 pulse + 8 RUN cycles in the window)
        c0 = ce_cnt;
        key_step_n = 1'b0;
        cyc(30);
        check("hold_ce_cycles", ce_cnt - c0, 9);
        check("hold_run", int'(run), 1);
        check("hold_ce", int'(clkEnable), 1);
        key_step_n = 1'b1;
        cyc(10);
        check("release_run", int'(run), 1);
        check("release_ce", int'(clkEnable), 1);
        // new press leaves RUN with no extra pulse
        c0 = ce_cnt;
        key_step_n = 1'b0;
        cyc(8);
        check("exit_run", int'(run), 0);
        key_step_n = 1'b1;
        cyc(10);
        check("exit_ce_cycles", ce_cnt - c0, 6);
        check("exit_ce", int'(clkEnable), 0);
        check("exit_run2", int'(run), 0);
        // register select wraps 31 -> 0
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("sel_start", int'(regAddr), 0);
        for (int i = 1; i <= 33; i++) begin
            key_sel_n = 1'b0;
            cyc(6);
            key_sel_n = 1'b1;
            cyc(6);
            check($sformatf("sel_%0d", i), int'(regAddr), i % 32);
        end
        check("sel_no_step", int'(run), 0);
        // simultaneous step and sel presses
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        c0 = ce_cnt;
        key_step_n = 1'b0;
        key_sel_n = 1'b0;
        cyc(6);
        check("both_pre_ce", int'(clkEnable), 0);
        check("both_pre_addr", int'(regAddr), 0);
        cyc(1);
        check("both_ce", int'(clkEnable), 1);
        check("both_addr", int'(regAddr), 1);
        key_step_n = 1'b1;
        key_sel_n = 1'b1;
        cyc(12);
        check("both_pulses", ce_cnt - c0, 1);
        // reset mid-hold aborts, held key is debounced afresh
        key_step_n = 1'b0;
        cyc(15);
        check("midhold_run", int'(run), 0);
        rst = 1'b1;
        cyc(2);
        check("midrst_ce", int'(clkEnable), 0);
        check("midrst_addr", int'(regAddr), 0);
        rst = 1'b0;
        c0 = ce_cnt;
        cyc(10);
        check("after_rst_run", int'(run), 0);
        key_step_n = 1'b1;
        cyc(10);
        check("after_rst_pulses", ce_cnt - c0, 1);
        check("after_rst_run2", int'(run), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
